cur_blk_fetch: RTL and testbench

//  Fetches one BLK x BLK block of current-frame luma from the byte-addressed

---
 rtl/cur_blk_fetch_if.sv | 35 +++
 rtl/cur_blk_fetch.sv | 144 ++++++++++++++
 tb/tb_cur_blk_fetch.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cur_blk_fetch_if.sv
// Bundle between the current-block fetcher and its environment: block request,
// frame-store read port and the pixel-beat stream toward the ME core.
interface cur_blk_fetch_if #(
    parameter int ADDR_W = 23,
    parameter int LANES  = 4
);
    logic                 start;
    logic [11:0]          blk_x;
    logic [11:0]          blk_y;
    logic                 busy;
    logic                 err;

    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [8*LANES-1:0]   mem_rdata;
    logic                 mem_rvalid;

    // Beat transfer: a beat moves on a rising edge where out_valid && out_ready;
    // out_valid never waits on out_ready, and while out_valid && !out_ready
    // the beat (out_data, out_last) is held unchanged.
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_data;
    logic                 out_last;

    modport master (
        input  start, blk_x, blk_y, mem_rdata, mem_rvalid, out_ready,
        output busy, err, mem_rd_en, mem_addr, out_valid, out_data, out_last
    );

    modport slave (
        output start, blk_x, blk_y, mem_rdata, mem_rvalid, out_ready,
        input  busy, err, mem_rd_en, mem_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/cur_blk_fetch.sv
// Fetches one BLK x BLK block of current-frame luma with in-order reads,
// credit-limited return FIFO and bottom-edge row clamping.
module cur_blk_fetch #(
    parameter int FRAME_W    = 3840,
    parameter int FRAME_H    = 2160,
    parameter int BLK        = 16,
    parameter int LANES      = 4,
    parameter int ADDR_W     = 23,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    cur_blk_fetch_if.master  bus,
    output logic [1:0]       dbg_state
);
    localparam int WPR = BLK / LANES;
    localparam int WPB = BLK * BLK / LANES;
    localparam int CW  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int RW  = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int BW  = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int NW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] FW       = ADDR_W'(FRAME_W);
    localparam logic [11:0]       LAST_ROW = 12'(FRAME_H - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;
    state_t state, state_nx;

    logic [11:0]        cur_row;
    logic [ADDR_W-1:0]  row_base;
    logic [RW-1:0]      row_cnt;
    logic [CW-1:0]      col_cnt;
    logic [NW-1:0]      outstanding;
    logic [NW-1:0]      fifo_count;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [8*LANES-1:0] fifo_mem [FIFO_DEPTH];
    logic [BW-1:0]      beat_cnt;

    logic coord_bad, accept, credit, issue, push, pop, last_col, last_word, blk_done;

    always_comb begin
        coord_bad = ((int'(bus.blk_x) % LANES) != 0)
                 || (int'(bus.blk_x) + BLK > FRAME_W)
                 || (int'(bus.blk_y) >= FRAME_H);
    end

    // Credit: every read in flight already owns a FIFO slot, so returns never overflow.
    assign credit    = ({1'b0, outstanding} + {1'b0, fifo_count}) < (NW+1)'(FIFO_DEPTH);
    assign accept    = (state == IDLE) && bus.start && !coord_bad;
    assign issue     = (state == ISSUE) && credit;
    assign last_col  = (col_cnt == CW'(WPR - 1));
    assign last_word = last_col && (row_cnt == RW'(BLK - 1));
    assign push      = bus.mem_rvalid;
    assign pop       = bus.out_valid && bus.out_ready;
    assign blk_done  = pop && bus.out_last;

    assign bus.busy      = (state != IDLE);
    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = row_base + ADDR_W'(col_cnt) * ADDR_W'(LANES);
    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_data  = fifo_mem[rd_ptr];
    assign bus.out_last  = bus.out_valid && (beat_cnt == BW'(WPB - 1));
    assign dbg_state     = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   if (issue && last_word) state_nx = DRAIN;
            DRAIN:   if (blk_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bus.err <= 1'b0;
        end else begin
            state   <= state_nx;
            bus.err <= (state == IDLE) && bus.start && coord_bad;
        end
    end

    // Row base tracks the clamped row; once at the bottom row it stops advancing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_row  <= '0;
            row_base <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
        end else if (accept) begin
            cur_row  <= bus.blk_y;
            row_base <= ADDR_W'(bus.blk_y) * FW + ADDR_W'(bus.blk_x);
            row_cnt  <= '0;
            col_cnt  <= '0;
        end else if (issue) begin
            if (last_col) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + RW'(1);
                if (cur_row != LAST_ROW) begin
                    cur_row  <= cur_row + 12'd1;
                    row_base <= row_base + FW;
                end
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            beat_cnt    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            case ({issue, push})
                2'b10:   outstanding <= outstanding + NW'(1);
                2'b01:   outstanding <= outstanding - NW'(1);
                default: ;
            endcase
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + NW'(1);
                2'b01:   fifo_count <= fifo_count - NW'(1);
                default: ;
            endcase
            if (push) begin
                fifo_mem[wr_ptr] <= bus.mem_rdata;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (blk_done)  beat_cnt <= '0;
            else if (pop)  beat_cnt <= beat_cnt + BW'(1);
        end
    end

    // A return with nothing in flight means the memory broke the read protocol.
    rvalid_tracked: assert property (@(posedge clk) disable iff (rst)
        !(bus.mem_rvalid && (outstanding == '0)));
endmodule

// File: tb/tb_cur_blk_fetch.sv
// Directed and randomised bench for cur_blk_fetch with a latency-varying
// in-order frame-store model and an expected-beat queue.
module tb_cur_blk_fetch;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  cur_blk_fetch_if #(.ADDR_W(23), .LANES(4)) bus ();

  cur_blk_fetch #(
    .FRAME_W(3840), .FRAME_H(2160), .BLK(16), .LANES(4), .ADDR_W(23), .FIFO_DEPTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic [22:0] addr;
    longint      due;
  } rd_t;

  int          ncheck = 0;
  int          nerr = 0;
  logic [31:0] exp_q[$];
  rd_t         mq[$];
  longint      cyc = 0;
  int          lat_lo = 3;
  int          lat_hi = 3;
  int          rdy_mode = 0;
  int          rd_cnt = 0;
  int          beat_cnt = 0;
  logic [22:0] addr_log[64];
  logic [31:0] data_log[64];

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] pix(input logic [22:0] a);
    return a[7:0] ^ a[15:8] ^ {a[22:16], 1'b0};
  endfunction

  function automatic logic [31:0] word(input logic [22:0] a);
    return {pix(a), pix(a + 23'd1), pix(a + 23'd2), pix(a + 23'd3)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncheck++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-store model, ready driver and beat scoreboard, all at the falling edge.
  initial begin
    rd_t h;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.out_ready  = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mq.delete();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
      end else begin
        case (rdy_mode)
          0:       bus.out_ready = 1'b1;
          1:       bus.out_ready = 1'b0;
          default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        if (bus.out_valid && bus.out_ready) begin
          if (beat_cnt < 64) data_log[beat_cnt] = bus.out_data;
          if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
          else chk("beat_data", bus.out_data, exp_q.pop_front());
          chk("beat_last", bus.out_last, (beat_cnt == 63));
          beat_cnt++;
        end
        if (bus.mem_rd_en) begin
          if (rd_cnt < 64) addr_log[rd_cnt] = bus.mem_addr;
          rd_cnt++;
          mq.push_back('{bus.mem_addr, cyc + longint'($urandom_range(lat_lo, lat_hi))});
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          h = mq.pop_front();
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = word(h.addr);
        end else begin
          bus.mem_rvalid = 1'b0;
          bus.mem_rdata  = '0;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_blk(input int x, input int y, input bit push_exp);
    int row;
    bus.blk_x = 12'(x);
    bus.blk_y = 12'(y);
    bus.start = 1'b1;
    rd_cnt = 0;
    beat_cnt = 0;
    if (push_exp)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 4; c++) begin
          row = (y + r > 2159) ? 2159 : y + r;
          exp_q.push_back(word(23'(row * 3840 + x + 4 * c)));
        end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((bus.busy || exp_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    chk("done_in_budget", (k < budget), 64'd1);
  endtask

  initial begin
    logic [31:0] held;
    int bx, by;
    int k;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.blk_x = '0;
    bus.blk_y = '0;
    tick(3);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_out_data", bus.out_data, 0);
    rst = 1'b0;
    tick(2);

    // block (16,16), latency 3, consumer always ready
    lat_lo = 3; lat_hi = 3; rdy_mode = 0;
    start_blk(16, 16, 1);
    chk("t2_busy", bus.busy, 1);
    chk("t2_first_rd", bus.mem_rd_en, 1);
    wait_done(400);
    chk("t2_reads", rd_cnt, 64);
    chk("t2_beats", beat_cnt, 64);
    chk("t2_addr0", addr_log[0], 64'd61456);
    chk("t2_addr3", addr_log[3], 64'd61468);
    chk("t2_addr4", addr_log[4], 64'd65296);
    chk("t2_addr63", addr_log[63], 64'd119068);
    chk("t2_busy_end", bus.busy, 0);

    // bottom-right corner with row clamp
    start_blk(3824, 2152, 1);
    wait_done(400);
    chk("t3_addr28", addr_log[28], 64'd8294384);
    chk("t3_addr32", addr_log[32], 64'd8294384);
    chk("t3_addr63", addr_log[63], 64'd8294396);
    chk("t3_data32", data_log[32], word(23'd8294384));
    chk("t3_data40", data_log[40], word(23'd8294384));
    chk("t3_data63", data_log[63], word(23'd8294396));

    // rejected coordinates
    for (int i = 0; i < 3; i++) begin
      bx = (i == 0) ? 3830 : (i == 1) ? 3832 : 0;
      by = (i == 2) ? 2160 : 0;
      start_blk(bx, by, 0);
      chk("t4_err", bus.err, 1);
      chk("t4_busy", bus.busy, 0);
      tick();
      chk("t4_err_pulse", bus.err, 0);
      tick(3);
      chk("t4_no_reads", rd_cnt, 0);
    end

    // consumer stalled for 50 cycles, latency 5; starts while busy are ignored
    lat_lo = 5; lat_hi = 5; rdy_mode = 1;
    start_blk(64, 100, 1);
    bus.blk_x = 12'd8; bus.blk_y = 12'd8; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t5_busy_start_no_err", bus.err, 0);
    bus.blk_x = 12'd0; bus.blk_y = 12'd2160; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t5_busy_bad_no_err", bus.err, 0);
    tick(47);
    chk("t5_reads_capped", rd_cnt, 8);
    chk("t5_no_beats", beat_cnt, 0);
    chk("t5_valid", bus.out_valid, 1);
    chk("t5_head", bus.out_data, word(23'd384064));
    held = bus.out_data;
    tick();
    chk("t5_head_stable", bus.out_data, held);
    chk("t5_reads_still", rd_cnt, 8);
    rdy_mode = 0;
    wait_done(400);
    chk("t5_beats", beat_cnt, 64);
    chk("t5_reads", rd_cnt, 64);

    // reset in the middle of a block
    lat_lo = 2; lat_hi = 2;
    start_blk(0, 0, 1);
    k = 0;
    while (beat_cnt < 20 && k < 200) begin
      tick();
      k++;
    end
    chk("t1_reached_20", (beat_cnt >= 20), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("t1_busy", bus.busy, 0);
    chk("t1_out_valid", bus.out_valid, 0);
    chk("t1_rd_en", bus.mem_rd_en, 0);
    rst = 1'b0;
    tick();
    start_blk(0, 0, 1);
    wait_done(400);
    chk("t1_beats", beat_cnt, 64);

    // random legal blocks, random ready and latency
    lat_lo = 1; lat_hi = 10; rdy_mode = 2;
    for (int i = 0; i < 100; i++) begin
      start_blk(4 * $urandom_range(0, 956), $urandom_range(0, 2159), 1);
      tick($urandom_range(0, 20));
      if (bus.busy) begin
        bus.blk_x = 12'($urandom_range(0, 4095));
        bus.blk_y = 12'($urandom_range(0, 4095));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t6_busy_start_no_err", bus.err, 0);
      end
      wait_done(2000);
      chk("t6_beats", beat_cnt, 64);
    end
    tick(3);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", ncheck, nerr);
    $finish;
  end
endmodule
